// File: rtl/clock_pkg.sv
// Shared definitions for the 12-hour clock: time-field width, set-sequencer states
// and the small field arithmetic helpers used while editing a time value.
package clock_pkg;
    localparam int STATE_W = 2;
    localparam int TIME_W  = 7;

    typedef enum logic [STATE_W-1:0] {
        RUN      = 2'd0,
        SET_HRS  = 2'd1,
        SET_MINS = 2'd2,
        COMMIT   = 2'd3
    } state_t;

    function automatic logic [TIME_W-1:0] wrapInc(input logic [TIME_W-1:0] value,
                                                  input logic [TIME_W-1:0] tc);
        return (value == tc) ? '0 : value + 1'b1;
    endfunction

    // Out-of-range captures from the core restart editing at zero.
    function automatic logic [TIME_W-1:0] clampField(input logic [TIME_W-1:0] value,
                                                     input logic [TIME_W-1:0] tc);
        return (value > tc) ? '0 : value;
    endfunction
endpackage

// File: rtl/clock_set_controller_btn_edge_sync.sv
// Two-flop synchronizer for a raw pushbutton followed by a rising-edge detector;
// a held button yields a single one-cycle pulse.
module btn_edge_sync (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn,
    output logic o_pulse
);
    logic r_sync1;
    logic r_sync2;
    logic r_prev;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign o_pulse = r_sync2 & ~r_prev;
endmodule

// File: rtl/clock_set_controller.sv
// Time-set sequencer: MODE walks RUN -> SET_HRS -> SET_MINS -> COMMIT, INC bumps the
// field being edited, and COMMIT issues a one-cycle active-low load to the clock core.
module clock_set_controller
    import clock_pkg::*;
#(
    parameter int hrs_tc_p   = 11,
    parameter int mins_tc_p  = 59,
    parameter int blink_tc_p = 24999999
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                modeBtn_i,
    input  logic                incBtn_i,
    input  logic [TIME_W-1:0]   curHrs_i,
    input  logic [TIME_W-1:0]   curMins_i,
    output logic [TIME_W-1:0]   loadHrs_o,
    output logic [TIME_W-1:0]   loadMins_o,
    output logic                nLoadNow_o,
    output logic                blankHrs_o,
    output logic                blankMins_o,
    output logic [STATE_W-1:0]  mode_o
);
    localparam int                 BLINK_W  = $clog2(blink_tc_p + 1);
    localparam logic [BLINK_W-1:0] BLINK_TC = BLINK_W'(blink_tc_p);
    localparam logic [TIME_W-1:0]  HRS_TC   = TIME_W'(hrs_tc_p);
    localparam logic [TIME_W-1:0]  MINS_TC  = TIME_W'(mins_tc_p);

    logic               w_modePulse;
    logic               w_incPulse;
    state_t             r_state;
    state_t             w_nextState;
    logic [TIME_W-1:0]  r_editHrs;
    logic [TIME_W-1:0]  r_editMins;
    logic [TIME_W-1:0]  w_nextHrs;
    logic [TIME_W-1:0]  w_nextMins;
    logic               r_nLoad;
    logic [BLINK_W-1:0] r_blinkCnt;
    logic               r_phase;
    logic               w_fieldEntry;

    btn_edge_sync u_modeSync (
        .i_clk   (clk_i),
        .i_rst   (rst_i),
        .i_btn   (modeBtn_i),
        .o_pulse (w_modePulse)
    );

    btn_edge_sync u_incSync (
        .i_clk   (clk_i),
        .i_rst   (rst_i),
        .i_btn   (incBtn_i),
        .o_pulse (w_incPulse)
    );

    // MODE is tested first everywhere so a coincident INC is dropped.
    always_comb begin
        w_nextState = r_state;
        w_nextHrs   = r_editHrs;
        w_nextMins  = r_editMins;
        case (r_state)
            RUN: begin
                if (w_modePulse) begin
                    w_nextState = SET_HRS;
                    w_nextHrs   = clampField(curHrs_i, HRS_TC);
                    w_nextMins  = clampField(curMins_i, MINS_TC);
                end
            end
            SET_HRS: begin
                if (w_modePulse)     w_nextState = SET_MINS;
                else if (w_incPulse) w_nextHrs   = wrapInc(r_editHrs, HRS_TC);
            end
            SET_MINS: begin
                if (w_modePulse)     w_nextState = COMMIT;
                else if (w_incPulse) w_nextMins  = wrapInc(r_editMins, MINS_TC);
            end
            COMMIT:  w_nextState = RUN;
            default: w_nextState = RUN;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= RUN;
            r_editHrs  <= '0;
            r_editMins <= '0;
            r_nLoad    <= 1'b1;
        end else begin
            r_state    <= w_nextState;
            r_editHrs  <= w_nextHrs;
            r_editMins <= w_nextMins;
            r_nLoad    <= (w_nextState != COMMIT);
        end
    end

    assign w_fieldEntry = (w_nextState != r_state) &&
                          ((w_nextState == SET_HRS) || (w_nextState == SET_MINS));

    // Restarting the blink on field entry makes each newly selected field visible first.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_blinkCnt <= '0;
            r_phase    <= 1'b0;
        end else if (w_fieldEntry) begin
            r_blinkCnt <= '0;
            r_phase    <= 1'b0;
        end else if (r_blinkCnt == BLINK_TC) begin
            r_blinkCnt <= '0;
            r_phase    <= ~r_phase;
        end else begin
            r_blinkCnt <= r_blinkCnt + 1'b1;
        end
    end

    assign loadHrs_o   = r_editHrs;
    assign loadMins_o  = r_editMins;
    assign nLoadNow_o  = r_nLoad;
    assign blankHrs_o  = (r_state == SET_HRS) & r_phase;
    assign blankMins_o = (r_state == SET_MINS) & r_phase;
    assign mode_o      = r_state;
endmodule

// File: tb/tb_clock_set_controller.sv
// Bench for clock_set_controller: button transactions update a behavioural model that
// queues expected mode steps and load strobes; a monitor pops and compares them.
module tb_clock_set_controller;
    localparam int HRS_TC   = 11;
    localparam int MINS_TC  = 59;
    localparam int BLINK_TC = 3;
    localparam int HALF     = BLINK_TC + 1;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       modeBtn_i;
    logic       incBtn_i;
    logic [6:0] curHrs_i;
    logic [6:0] curMins_i;
    logic [6:0] loadHrs_o;
    logic [6:0] loadMins_o;
    logic       nLoadNow_o;
    logic       blankHrs_o;
    logic       blankMins_o;
    logic [1:0] mode_o;

    int checks   = 0;
    int failures = 0;
    int expModeQ[$];
    int expLoadQ[$];
    int mState   = 0;
    int mHrs     = 0;
    int mMins    = 0;
    bit monEn    = 1'b0;
    int lastMode = 0;
    int expMode  = 0;
    int inState  = 0;

    clock_set_controller #(
        .hrs_tc_p   (HRS_TC),
        .mins_tc_p  (MINS_TC),
        .blink_tc_p (BLINK_TC)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .modeBtn_i   (modeBtn_i),
        .incBtn_i    (incBtn_i),
        .curHrs_i    (curHrs_i),
        .curMins_i   (curMins_i),
        .loadHrs_o   (loadHrs_o),
        .loadMins_o  (loadMins_o),
        .nLoadNow_o  (nLoadNow_o),
        .blankHrs_o  (blankHrs_o),
        .blankMins_o (blankMins_o),
        .mode_o      (mode_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic modelMode();
        case (mState)
            0: begin
                mState = 1;
                mHrs   = (int'(curHrs_i) > HRS_TC) ? 0 : int'(curHrs_i);
                mMins  = (int'(curMins_i) > MINS_TC) ? 0 : int'(curMins_i);
                expModeQ.push_back(1);
            end
            1: begin
                mState = 2;
                expModeQ.push_back(2);
            end
            default: begin
                mState = 0;
                expModeQ.push_back(3);
                expLoadQ.push_back(mHrs * 100 + mMins);
                expModeQ.push_back(0);
            end
        endcase
    endtask

    task automatic modelInc();
        if (mState == 1)      mHrs  = (mHrs == HRS_TC) ? 0 : mHrs + 1;
        else if (mState == 2) mMins = (mMins == MINS_TC) ? 0 : mMins + 1;
    endtask

    task automatic applyStimulus(input bit m, input bit i, input int hold);
        if (m)      modelMode();
        else if (i) modelInc();
        @(negedge clk_i);
        modeBtn_i = m;
        incBtn_i  = i;
        repeat (hold) @(negedge clk_i);
        modeBtn_i = 1'b0;
        incBtn_i  = 1'b0;
        repeat (5) @(negedge clk_i);
    endtask

    always @(negedge clk_i) begin
        if (monEn) begin
            if (int'(mode_o) != lastMode) begin
                lastMode = int'(mode_o);
                inState  = 0;
                if (expModeQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL modeStep: got %0d expected no change", mode_o);
                end else begin
                    expMode = expModeQ.pop_front();
                    checkOutput("modeStep", int'(mode_o), expMode);
                end
            end else begin
                inState++;
            end
            checkOutput("blankHrs", int'(blankHrs_o),
                        (expMode == 1 && ((inState / HALF) % 2) == 1) ? 1 : 0);
            checkOutput("blankMins", int'(blankMins_o),
                        (expMode == 2 && ((inState / HALF) % 2) == 1) ? 1 : 0);
            if (nLoadNow_o == 1'b0) begin
                if (expLoadQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL loadStrobe: got low expected high");
                end else begin
                    int e;
                    e = expLoadQ.pop_front();
                    checkOutput("loadHrs", int'(loadHrs_o), e / 100);
                    checkOutput("loadMins", int'(loadMins_o), e % 100);
                    checkOutput("commitMode", int'(mode_o), 3);
                end
            end
        end
    end

    initial begin
        rst_i     = 1'b1;
        modeBtn_i = 1'b0;
        incBtn_i  = 1'b0;
        curHrs_i  = '0;
        curMins_i = '0;
        repeat (3) @(negedge clk_i);
        checkOutput("rstMode", int'(mode_o), 0);
        checkOutput("rstNLoad", int'(nLoadNow_o), 1);
        checkOutput("rstLoadHrs", int'(loadHrs_o), 0);
        checkOutput("rstLoadMins", int'(loadMins_o), 0);
        rst_i = 1'b0;
        monEn = 1'b1;
        repeat (100) @(negedge clk_i);
        checkOutput("idleMode", int'(mode_o), 0);

        curHrs_i  = 7'd10;
        curMins_i = 7'd58;
        applyStimulus(1'b1, 1'b0, 2);
        repeat (3) applyStimulus(1'b0, 1'b1, 1);
        applyStimulus(1'b1, 1'b0, 1);
        repeat (2) applyStimulus(1'b0, 1'b1, 1);
        applyStimulus(1'b1, 1'b0, 3);
        checkOutput("holdHrs", int'(loadHrs_o), 1);
        checkOutput("holdMins", int'(loadMins_o), 0);
        checkOutput("afterCommitMode", int'(mode_o), 0);

        curHrs_i  = 7'd5;
        curMins_i = 7'd30;
        applyStimulus(1'b1, 1'b0, 1);
        applyStimulus(1'b0, 1'b1, 1);
        applyStimulus(1'b1, 1'b1, 2);
        checkOutput("bothEditHrs", int'(loadHrs_o), 6);
        checkOutput("bothMode", int'(mode_o), 2);
        applyStimulus(1'b0, 1'b1, 1);
        applyStimulus(1'b1, 1'b0, 1);

        curHrs_i  = 7'd3;
        curMins_i = 7'd20;
        applyStimulus(1'b1, 1'b0, 1);
        applyStimulus(1'b1, 1'b0, 1);
        applyStimulus(1'b0, 1'b1, 50);
        checkOutput("heldIncMins", int'(loadMins_o), 21);
        @(negedge clk_i);
        #1 modeBtn_i = 1'b1;
        #2 modeBtn_i = 1'b0;
        repeat (6) @(negedge clk_i);
        checkOutput("narrowMode", int'(mode_o), 2);

        @(negedge clk_i);
        expModeQ.push_back(0);
        #2 rst_i = 1'b1;
        #1;
        checkOutput("asyncRstMode", int'(mode_o), 0);
        checkOutput("asyncRstNLoad", int'(nLoadNow_o), 1);
        checkOutput("asyncRstBlankMins", int'(blankMins_o), 0);
        checkOutput("asyncRstLoadHrs", int'(loadHrs_o), 0);
        checkOutput("asyncRstLoadMins", int'(loadMins_o), 0);
        mState = 0;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        repeat (10) @(negedge clk_i);

        repeat (60) begin
            int r;
            curHrs_i  = 7'($urandom_range(0, 127));
            curMins_i = 7'($urandom_range(0, 127));
            r = $urandom_range(0, 9);
            if (r < 4)      applyStimulus(1'b1, 1'b0, $urandom_range(1, 4));
            else if (r < 8) applyStimulus(1'b0, 1'b1, $urandom_range(1, 4));
            else            applyStimulus(1'b1, 1'b1, $urandom_range(1, 4));
        end
        while (mState != 0) applyStimulus(1'b1, 1'b0, 1);

        repeat (20) @(negedge clk_i);
        checkOutput("modeQueueDrained", expModeQ.size(), 0);
        checkOutput("loadQueueDrained", expLoadQ.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
